aging_priority_arbiter: RTL and testbench
=========================================

Name: aging_priority_arbiter

Overview:
- Shares one downstream issue port between NUM_REQUEST requesters, each using a valid/ack handshake.
- Critical requests normally win; ties within a priority class resolve round-robin.
- A per-requester aging counter promotes a starved requester above critical traffic, which bounds worst-case latency.
- Sits between the request queues and the single issue slot, as a drop-in replacement for the plain priority arbiter.

Parameters:
- NUM_REQUEST, 3, number of requesters
- SINGLE_REQUEST_WIDTH_IN_BITS, 64, payload width per request
- STARVE_LIMIT, 4, number of lost arbitrations before promotion; 0 disables aging
- AGE_WIDTH, clog2(STARVE_LIMIT+1) (minimum 1), width of each age counter

Ports:
- clk_in  in  1  clock
- reset_n_in  in  1  reset; one clock; asynchronous, active-low
- request_flatted_in  in  NUM_REQUEST*SINGLE_REQUEST_WIDTH_IN_BITS  packed payloads; way i at bits [i*W +: W]
- request_valid_flatted_in  in  NUM_REQUEST  per-way valid
- request_critical_flatted_in  in  NUM_REQUEST  per-way critical flag
- issue_ack_out  out  NUM_REQUEST  one-hot; way's request latched this cycle
- request_out  out  SINGLE_REQUEST_WIDTH_IN_BITS  registered granted payload
- request_valid_out  out  1  output slot full
- grant_way_out  out  clog2(NUM_REQUEST)  way index of the request held in request_out
- issue_ack_in  in  1  consumer accepts request_out this cycle

Behaviour:
- Reset (reset_n_in low, asynchronous):
  - request_out, request_valid_out and grant_way_out go to 0; any pending request is dropped.
  - All age counters go to 0; the round-robin pointer goes to 0.
  - issue_ack_out is 0 while reset_n_in is low.
- Arbitration occurs in any cycle where the slot is free (request_valid_out=0) and at least one way is valid.
- Priority classes, highest first:
  - PROMOTED: valid and age==STARVE_LIMIT, with STARVE_LIMIT>0.
  - CRITICAL: valid and critical flag set.
  - NORMAL: valid.
- The winner is the first way in the highest non-empty class, searching circularly from rr_ptr upward.
- issue_ack_out[winner] is combinational and high in the arbitration cycle. The requester advances its request on that edge.
- At the arbitration edge:
  - request_out is loaded with the winner's payload; request_valid_out and grant_way_out update.
  - rr_ptr becomes (winner+1) mod NUM_REQUEST.
- Aging:
  - Evaluated only on arbitration edges.
  - The winner's age is cleared to 0.
  - Each other valid, non-winning way increments its age, saturating at STARVE_LIMIT.
  - Invalid ways hold their age. No aging occurs while the slot is full (back-pressure).
- Slot drain: issue_ack_in with request_valid_out=1 clears request_valid_out at the edge. issue_ack_in with request_valid_out=0 is ignored.
- Latency and throughput:
  - A request is visible on request_out one edge after its issue_ack_out.
  - Base throughput is 1 grant per 2 cycles: there is no refill in the drain cycle.
- request_out and grant_way_out hold stable while request_valid_out=1 and issue_ack_in=0.
- Inputs of non-winning ways are ignored; requesters must hold valid and payload until acked.
- With a single valid way, that way wins regardless of class, and rr_ptr still advances.

Optional Feature:
- Macro: AGING_PRIORITY_ARBITER_PIPELINED_EN.
- Defined: arbitration is also allowed when request_valid_out=1 and issue_ack_in=1.
  - The slot drains and refills at the same edge, giving 1 grant per cycle.
  - issue_ack_out then depends combinationally on issue_ack_in.
- Undefined: arbitration only when the slot is empty; no combinational path from issue_ack_in to issue_ack_out.

Decomposition:
- Add to the shared parameters.h header:
  - Class encodings PROMOTED=2, CRITICAL=1, NORMAL=0.
  - A clog2 constant function.
- Natural sub-module: rr_priority_picker, combinational.
  - Inputs: an NUM_REQUEST-bit candidate vector and rr_ptr.
  - Outputs: one-hot grant, index, any_valid.
  - Instantiated once on the highest non-empty class vector, chosen by a 3-way priority mux.
- Age counters, rr_ptr and the output slot stay in aging_priority_arbiter.

Test Plan (NUM_REQUEST=3, W=64, STARVE_LIMIT=4 unless stated):
- Reset: pull reset_n_in low mid-transfer with request_valid_out=1 -> request_valid_out, request_out and issue_ack_out all 0 before the next clk edge; after release, the first grant goes to way 0.
- Round-robin: all ways valid, non-critical, issue_ack_in given the cycle after each valid -> grant_way_out sequence 0,1,2,0,1,2; a new grant every 2 cycles.
- Aging: way 0 always valid and critical, ways 1/2 valid and normal, immediate ack -> grant sequence 0,0,0,0,1,2,0,0,0,1,2,0,0,0,1,2.
- Back-pressure: hold issue_ack_in low 20 cycles with all ways valid -> request_out stable, issue_ack_out all 0, ages unchanged; after the ack, the next grant follows rr_ptr.
- STARVE_LIMIT=0: way 0 critical for 16 requests, ways 1/2 normal -> first 16 grants all way 0, then ways 1,2 alternate.
- PIPELINED_EN defined: 3 ways valid, issue_ack_in tied high whenever valid -> one grant per cycle, sequence 0,1,2,0,...; with the macro undefined, the same stimulus gives one grant per 2 cycles.

Source files
------------

// File: rtl/aging_priority_arbiter_pkg.sv
// rtl/aging_priority_arbiter_pkg.sv - shared class encodings and width helpers for the aging arbiter
package aging_priority_arbiter_pkg;

  typedef enum logic [1:0] {
    CLASS_NORMAL   = 2'd0,
    CLASS_CRITICAL = 2'd1,
    CLASS_PROMOTED = 2'd2
  } req_class_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // Index/counter widths never collapse to zero bits
  function automatic int width_of(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/aging_priority_arbiter_rr_priority_picker.sv
// rtl/aging_priority_arbiter_rr_priority_picker.sv - combinational first-set picker searching circularly from rr_ptr
module rr_priority_picker
  import aging_priority_arbiter_pkg::*;
#(
  parameter int NUM_REQUEST = 3,
  localparam int IDX_W = width_of(NUM_REQUEST)
) (
  input  logic [NUM_REQUEST-1:0] candidate,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [NUM_REQUEST-1:0] grant_onehot,
  output logic [IDX_W-1:0]       grant_index,
  output logic                   any_valid
);

  always_comb begin : pick
    int   way;
    logic found;
    way          = 0;
    found        = 1'b0;
    grant_onehot = '0;
    grant_index  = '0;
    any_valid    = |candidate;
    for (int off = 0; off < NUM_REQUEST; off++) begin
      way = (int'(rr_ptr) + off) % NUM_REQUEST;
      if (!found && candidate[way]) begin
        found             = 1'b1;
        grant_onehot[way] = 1'b1;
        grant_index       = IDX_W'(way);
      end
    end
  end

endmodule

// File: rtl/aging_priority_arbiter.sv
// rtl/aging_priority_arbiter.sv - aging priority arbiter feeding one registered issue slot
// Optional AGING_PRIORITY_ARBITER_PIPELINED_EN: refill the slot in the same cycle it drains.
module aging_priority_arbiter
  import aging_priority_arbiter_pkg::*;
#(
  parameter int NUM_REQUEST = 3,
  parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int AGE_WIDTH = width_of(STARVE_LIMIT + 1),
  localparam int IDX_W = width_of(NUM_REQUEST)
) (
  input  logic                                                clk_in,
  input  logic                                                reset_n_in,
  input  logic [NUM_REQUEST*SINGLE_REQUEST_WIDTH_IN_BITS-1:0] request_flatted_in,
  input  logic [NUM_REQUEST-1:0]                              request_valid_flatted_in,
  input  logic [NUM_REQUEST-1:0]                              request_critical_flatted_in,
  output logic [NUM_REQUEST-1:0]                              issue_ack_out,
  output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_out,
  output logic                                                request_valid_out,
  output logic [IDX_W-1:0]                                    grant_way_out,
  input  logic                                                issue_ack_in
);

  localparam int W = SINGLE_REQUEST_WIDTH_IN_BITS;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = AGE_WIDTH'(STARVE_LIMIT);
  localparam logic [IDX_W-1:0] LAST_WAY = IDX_W'(NUM_REQUEST - 1);

  logic [AGE_WIDTH-1:0]   age_q [NUM_REQUEST];
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [W-1:0]           request_q;
  logic                   slot_valid_q;
  logic [IDX_W-1:0]       grant_way_q;

  logic [NUM_REQUEST-1:0] promoted_vec;
  logic [NUM_REQUEST-1:0] critical_vec;
  logic [NUM_REQUEST-1:0] candidate_vec;
  logic [NUM_REQUEST-1:0] grant_onehot;
  logic [IDX_W-1:0]       grant_index;
  logic                   any_valid;
  logic                   slot_free;
  logic                   arb_fire;
  req_class_e             top_class;

  always_comb begin
    promoted_vec = '0;
    for (int i = 0; i < NUM_REQUEST; i++) begin
      promoted_vec[i] = (STARVE_LIMIT > 0) && request_valid_flatted_in[i] && (age_q[i] == AGE_MAX);
    end
    critical_vec = request_valid_flatted_in & request_critical_flatted_in;
    if (|promoted_vec)      top_class = CLASS_PROMOTED;
    else if (|critical_vec) top_class = CLASS_CRITICAL;
    else                    top_class = CLASS_NORMAL;
    case (top_class)
      CLASS_PROMOTED: candidate_vec = promoted_vec;
      CLASS_CRITICAL: candidate_vec = critical_vec;
      default:        candidate_vec = request_valid_flatted_in;
    endcase
  end

  rr_priority_picker #(
    .NUM_REQUEST(NUM_REQUEST)
  ) u_picker (
    .candidate   (candidate_vec),
    .rr_ptr      (rr_ptr_q),
    .grant_onehot(grant_onehot),
    .grant_index (grant_index),
    .any_valid   (any_valid)
  );

`ifdef AGING_PRIORITY_ARBITER_PIPELINED_EN
  assign slot_free = !slot_valid_q || issue_ack_in;
`else
  assign slot_free = !slot_valid_q;
`endif

  assign arb_fire      = slot_free && any_valid;
  // Gated by reset so requesters never advance while the slot is being cleared
  assign issue_ack_out = (arb_fire && reset_n_in) ? grant_onehot : '0;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      request_q    <= '0;
      slot_valid_q <= 1'b0;
      grant_way_q  <= '0;
      rr_ptr_q     <= '0;
    end else if (arb_fire) begin
      request_q    <= request_flatted_in[int'(grant_index)*W +: W];
      slot_valid_q <= 1'b1;
      grant_way_q  <= grant_index;
      rr_ptr_q     <= (grant_index == LAST_WAY) ? '0 : grant_index + 1'b1;
    end else if (issue_ack_in) begin
      slot_valid_q <= 1'b0;
    end
  end

  // Ages move only on arbitration edges, so back-pressure freezes them
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < NUM_REQUEST; i++) age_q[i] <= '0;
    end else if (arb_fire) begin
      for (int i = 0; i < NUM_REQUEST; i++) begin
        if (grant_onehot[i])
          age_q[i] <= '0;
        else if (request_valid_flatted_in[i] && (age_q[i] != AGE_MAX))
          age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  assign request_out       = request_q;
  assign request_valid_out = slot_valid_q;
  assign grant_way_out     = grant_way_q;

endmodule

// File: tb/tb_aging_priority_arbiter.sv
// tb/tb_aging_priority_arbiter.sv - scoreboard bench for aging_priority_arbiter (honours AGING_PRIORITY_ARBITER_PIPELINED_EN)
module tb_aging_priority_arbiter;

  localparam int N = 3;
  localparam int W = 64;
  localparam int LIMIT = 4;
`ifdef AGING_PRIORITY_ARBITER_PIPELINED_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic           reset_n_in;
  logic [N*W-1:0] req_flat;
  logic [N-1:0]   valid_flat;
  logic [N-1:0]   crit_flat;
  logic           issue_ack_in;
  logic           sel;

  logic [N-1:0] ack_a, ack_b, ack_o;
  logic [W-1:0] rq_a, rq_b, rq_o;
  logic         rv_a, rv_b, rv_o;
  logic [1:0]   gw_a, gw_b, gw_o;

  assign ack_o = sel ? ack_b : ack_a;
  assign rq_o  = sel ? rq_b  : rq_a;
  assign rv_o  = sel ? rv_b  : rv_a;
  assign gw_o  = sel ? gw_b  : gw_a;

  aging_priority_arbiter #(.NUM_REQUEST(N), .SINGLE_REQUEST_WIDTH_IN_BITS(W), .STARVE_LIMIT(LIMIT)) dut_a (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .request_flatted_in(req_flat),
    .request_valid_flatted_in(valid_flat), .request_critical_flatted_in(crit_flat),
    .issue_ack_out(ack_a), .request_out(rq_a), .request_valid_out(rv_a),
    .grant_way_out(gw_a), .issue_ack_in(issue_ack_in));

  aging_priority_arbiter #(.NUM_REQUEST(N), .SINGLE_REQUEST_WIDTH_IN_BITS(W), .STARVE_LIMIT(0)) dut_b (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .request_flatted_in(req_flat),
    .request_valid_flatted_in(valid_flat), .request_critical_flatted_in(crit_flat),
    .issue_ack_out(ack_b), .request_out(rq_b), .request_valid_out(rv_b),
    .grant_way_out(gw_b), .issue_ack_in(issue_ack_in));

  typedef struct {
    int           way;
    logic [W-1:0] pay;
  } exp_t;

  exp_t sb_q[$];
  int   m_age[N];
  int   m_rr;
  bit   m_full;
  int   m_limit;

  bit           pend[N];
  logic [W-1:0] pay[N];
  bit           crit[N];
  int           refill_pct, crit_mode, w0_budget, ack_mode;

  int grant_log[$];
  int grant_cyc[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Winner = highest class, then closest circularly at/after the rr pointer
  function automatic int pick_winner();
    int best, best_key, cls, key;
    best = -1;
    best_key = -1;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        cls = (m_limit > 0 && m_age[i] >= m_limit) ? 2 : (crit[i] ? 1 : 0);
        key = cls * N + (N - 1 - ((i - m_rr + N) % N));
        if (key > best_key) begin
          best_key = key;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_age[i] = 0;
    m_rr = 0;
    m_full = 1'b0;
    sb_q.delete();
    grant_log.delete();
    grant_cyc.delete();
  endtask

  task automatic do_cycle();
    int w;
    bit slot_free, arb;
    logic [N-1:0] exp_ack;
    @(negedge clk_in);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && (i != 0 || w0_budget != 0) && $urandom_range(1, 100) <= refill_pct) begin
        if (i == 0 && w0_budget > 0) w0_budget--;
        pend[i] = 1'b1;
        pay[i]  = {$urandom, $urandom};
        crit[i] = (crit_mode == 0) ? 1'($urandom_range(0, 1)) : (crit_mode == 1) ? (i == 0) : 1'b0;
      end
      req_flat[i*W +: W] = pay[i];
      valid_flat[i] = pend[i];
      crit_flat[i]  = crit[i];
    end
    case (ack_mode)
      0:       issue_ack_in = 1'($urandom_range(0, 1));
      1:       issue_ack_in = m_full;
      default: issue_ack_in = 1'b0;
    endcase
    #1;
    slot_free = !m_full || (PIPE && issue_ack_in);
    w = pick_winner();
    arb = slot_free && (w >= 0);
    exp_ack = arb ? N'(1 << w) : '0;
    chk("issue_ack_out", ack_o, exp_ack);
    chk("request_valid_out", rv_o, m_full);
    if (ack_mode == 2 && m_full && sb_q.size() > 0) chk("bp_hold", rq_o, sb_q[0].pay);
    if (arb) begin
      sb_q.push_back('{way: w, pay: pay[w]});
      grant_log.push_back(w);
      grant_cyc.push_back(cyc);
      for (int i = 0; i < N; i++) begin
        if (i == w) m_age[i] = 0;
        else if (pend[i] && m_age[i] < m_limit) m_age[i]++;
      end
      m_rr = (w + 1) % N;
      m_full = 1'b1;
      pend[w] = 1'b0;
    end else if (m_full && issue_ack_in) begin
      m_full = 1'b0;
    end
  endtask

  task automatic run_grants(input int n, input int max_cyc);
    int c;
    c = 0;
    while (grant_log.size() < n && c < max_cyc) begin
      do_cycle();
      c++;
    end
    chk("grant_timeout", grant_log.size(), n);
  endtask

  task automatic do_reset(input bit check_mid, input bit new_sel);
    @(negedge clk_in);
    if (check_mid) chk("pre_reset_valid", rv_o, m_full);
    reset_n_in = 1'b0;
    if (check_mid) begin
      for (int i = 0; i < N; i++) pend[i] = 1'b1;
      valid_flat = '1;
    end
    #1;
    if (check_mid) begin
      chk("rst_request_valid_out", rv_o, 0);
      chk("rst_request_out", rq_o, 0);
      chk("rst_issue_ack_out", ack_o, 0);
    end
    sel = new_sel;
    m_limit = new_sel ? 0 : LIMIT;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    valid_flat = '0;
    issue_ack_in = 1'b0;
    model_reset();
    @(negedge clk_in);
    reset_n_in = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_in);
      #2;
      if (reset_n_in && rv_o && issue_ack_in) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          chk("grant_way_out", gw_o, e.way);
          chk("request_out", rq_o, e.pay);
        end
      end
    end
  end

  initial begin : stimulus
    int exp_rr[6];
    int exp_age[16];
    int exp_nl[22];
    int n0;
    exp_rr  = '{0, 1, 2, 0, 1, 2};
    exp_age = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2};
    for (int k = 0; k < 22; k++) exp_nl[k] = (k < 16) ? 0 : ((k % 2 == 0) ? 1 : 2);

    sel = 1'b0;
    m_limit = LIMIT;
    reset_n_in = 1'b1;
    req_flat = '0;
    valid_flat = '0;
    crit_flat = '0;
    issue_ack_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pay[i] = '0;
      crit[i] = 1'b0;
    end
    model_reset();
    #2 reset_n_in = 1'b0;
    #1;
    chk("reset_request_valid_out", rv_o, 0);
    chk("reset_request_out", rq_o, 0);
    chk("reset_grant_way_out", gw_o, 0);
    repeat (2) @(negedge clk_in);
    reset_n_in = 1'b1;

    // Round-robin with immediate consumer ack
    refill_pct = 100; crit_mode = 2; ack_mode = 1; w0_budget = -1;
    run_grants(6, 40);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) chk("rr_sequence", grant_log[k], exp_rr[k]);
    for (int k = 1; k < 6 && k < grant_cyc.size(); k++)
      chk("grant_spacing", grant_cyc[k] - grant_cyc[k-1], PIPE ? 1 : 2);

    // Aging lifts starved normal ways over a permanently critical way 0
    do_reset(1'b0, 1'b0);
    refill_pct = 100; crit_mode = 1; ack_mode = 1;
    run_grants(16, 100);
    for (int k = 0; k < 16 && k < grant_log.size(); k++) chk("aging_sequence", grant_log[k], exp_age[k]);

    // Back-pressure then release
    ack_mode = 2;
    repeat (20) do_cycle();
    ack_mode = 1;
    n0 = grant_log.size();
    run_grants(n0 + 6, 60);

    // Random traffic, then a reset mid-transfer
    crit_mode = 0; refill_pct = 40; ack_mode = 0;
    repeat (300) do_cycle();
    n0 = 0;
    while (!m_full && n0 < 50) begin
      do_cycle();
      n0++;
    end
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      crit[i] = 1'b0;
    end
    crit_mode = 2; refill_pct = 100; ack_mode = 1;
    run_grants(1, 10);
    if (grant_log.size() > 0) chk("first_grant_after_reset", grant_log[0], 0);

    // Aging disabled: critical way 0 monopolises until its 16 requests run out
    do_reset(1'b0, 1'b1);
    crit_mode = 1; refill_pct = 100; ack_mode = 1; w0_budget = 16;
    run_grants(22, 150);
    for (int k = 0; k < 22 && k < grant_log.size(); k++) chk("no_aging_sequence", grant_log[k], exp_nl[k]);

    do_reset(1'b0, 1'b1);
    crit_mode = 0; refill_pct = 50; ack_mode = 0; w0_budget = -1;
    repeat (300) do_cycle();

    @(negedge clk_in);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
